mem_access_unit: RTL and testbench

- Downstream consumer of the 16-bit Address produced by the SAYEH addressing unit.
- Turns single-cycle read/write requests from the controller into a handshaked external memory cycle with variable wait states and a timeout.
- Returns read data to the datapath and optionally loads the instruction register (IR).
- Signals completion (done) or timeout (err) back to the controller so it can advance PC.

---
 rtl/mem_access_unit_pkg.sv | 16 +
 rtl/mem_access_unit_timer.sv | 34 +++
 rtl/mem_access_unit.sv | 142 ++++++++++++++
 tb/tb_mem_access_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the SAYEH memory access unit and its neighbours.
package mem_access_unit_pkg;

   // Address/data widths shared with the addressing unit.
   localparam int DEF_AW      = 16;
   localparam int DEF_DW      = 16;
   // Default number of wait cycles before a stalled access is abandoned.
   localparam int DEF_TIMEOUT = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } mau_state_t;

endpackage

// File: rtl/mem_access_unit_timer.sv
// Wait-state counter: counts edges spent waiting for mem_ready and flags the last one.
import mem_access_unit_pkg::*;

module mem_wait_timer #(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   // One extra count of headroom so the increment on the expiring edge cannot wrap.
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] count;

   // Counter register; clear has priority over increment.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

   // Last permitted wait edge.
   assign expired = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Converts single-cycle read/write requests into a handshaked memory cycle with timeout.
import mem_access_unit_pkg::*;

module mem_access_unit #(
   parameter int AW      = DEF_AW,
   parameter int DW      = DEF_DW,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] Address,
   input  logic          rd_req,
   input  logic          wr_req,
   input  logic          ir_load,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic [DW-1:0] ir,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready
);

   mau_state_t    state, state_nxt;
   logic          ir_flag, ir_flag_nxt;
   logic [DW-1:0] rdata_nxt, ir_nxt, mem_wdata_nxt;
   logic [AW-1:0] mem_addr_nxt;
   logic          busy_nxt, done_nxt, err_nxt, mem_rd_nxt, mem_wr_nxt;
   logic          tmr_clear, tmr_inc, tmr_expired;

   // Timer is held at zero while idle, so it starts from zero on every access.
   assign tmr_clear = (state == IDLE);
   assign tmr_inc   = (state != IDLE) && !mem_ready;

   mem_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (tmr_clear),
      .inc     (tmr_inc),
      .expired (tmr_expired)
   );

   // Next-state and next-output logic; every output is registered below.
   // NOTE: every signal gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt     = state;
      ir_flag_nxt   = ir_flag;
      rdata_nxt     = rdata;
      ir_nxt        = ir;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      mem_rd_nxt    = mem_rd;
      mem_wr_nxt    = mem_wr;
      busy_nxt      = busy;
      done_nxt      = 1'b0;
      err_nxt       = 1'b0;

      case (state)
         IDLE: begin
            // Read wins over a simultaneous write; the write is silently dropped.
            if (rd_req) begin
               mem_addr_nxt = Address;
               ir_flag_nxt  = ir_load;
               mem_rd_nxt   = 1'b1;
               busy_nxt     = 1'b1;
               state_nxt    = READ;
            end else if (wr_req) begin
               mem_addr_nxt  = Address;
               mem_wdata_nxt = wdata;
               mem_wr_nxt    = 1'b1;
               busy_nxt      = 1'b1;
               state_nxt     = WRITE;
            end
         end

         READ, WRITE: begin
            // Completion takes priority over a timeout on the same edge.
            if (mem_ready) begin
               done_nxt = 1'b1;
               if (state == READ) begin
                  rdata_nxt = mem_rdata;
                  if (ir_flag) begin
                     ir_nxt = mem_rdata;
                  end
               end
            end else if (tmr_expired) begin
               err_nxt = 1'b1;
            end
            if (mem_ready || tmr_expired) begin
               mem_rd_nxt = 1'b0;
               mem_wr_nxt = 1'b0;
               busy_nxt   = 1'b0;
               state_nxt  = IDLE;
            end
         end

         default: begin
            mem_rd_nxt = 1'b0;
            mem_wr_nxt = 1'b0;
            busy_nxt   = 1'b0;
            state_nxt  = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ir_flag   <= 1'b0;
         rdata     <= '0;
         ir        <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nxt;
         ir_flag   <= ir_flag_nxt;
         rdata     <= rdata_nxt;
         ir        <= ir_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         mem_rd    <= mem_rd_nxt;
         mem_wr    <= mem_wr_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         err       <= err_nxt;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT = 15).
module tb_mem_access_unit;

   logic        clk;
   logic        rst_n;
   logic [15:0] Address;
   logic        rd_req, wr_req, ir_load;
   logic [15:0] wdata;
   logic [15:0] rdata, ir;
   logic        busy, done, err;
   logic [15:0] mem_addr;
   logic        mem_rd, mem_wr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ready;

   int n_cmp = 0;
   int n_bad = 0;

   mem_access_unit #(
      .AW      (16),
      .DW      (16),
      .TIMEOUT (15)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .Address   (Address),
      .rd_req    (rd_req),
      .wr_req    (wr_req),
      .ir_load   (ir_load),
      .wdata     (wdata),
      .rdata     (rdata),
      .ir        (ir),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Watchdog so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int  cycles;
   logic seen_done;

   initial begin
      rst_n = 1'b0; Address = '0; rd_req = 0; wr_req = 0; ir_load = 0;
      wdata = '0; mem_rdata = '0; mem_ready = 0;

      // ---- reset state ----
      tick(); tick();
      chk("rst_busy",  32'(busy),     32'd0);
      chk("rst_memrd", 32'(mem_rd),   32'd0);
      chk("rst_memwr", 32'(mem_wr),   32'd0);
      chk("rst_rdata", 32'(rdata),    32'd0);
      chk("rst_ir",    32'(ir),       32'd0);
      chk("rst_addr",  32'(mem_addr), 32'd0);
      chk("rst_done",  32'(done),     32'd0);
      #3 rst_n = 1'b1;
      tick();

      // ---- zero-wait read with IR load ----
      Address = 16'h0040; rd_req = 1; ir_load = 1;
      tick();                                   // E0
      rd_req = 0; ir_load = 0; Address = 16'hFFFF;
      chk("zr_memrd", 32'(mem_rd),   32'd1);
      chk("zr_busy",  32'(busy),     32'd1);
      chk("zr_addr",  32'(mem_addr), 32'h0040);
      chk("zr_done0", 32'(done),     32'd0);
      mem_ready = 1; mem_rdata = 16'hA5C3;
      tick();                                   // E1
      mem_ready = 0; mem_rdata = 16'h0000;
      chk("zr_done",  32'(done),   32'd1);
      chk("zr_rdata", 32'(rdata),  32'hA5C3);
      chk("zr_ir",    32'(ir),     32'hA5C3);
      chk("zr_memrd0",32'(mem_rd), 32'd0);
      chk("zr_busy0", 32'(busy),   32'd0);
      tick();
      chk("zr_done1", 32'(done),   32'd0);

      // ---- write with 5-cycle strobe ----
      Address = 16'h1234; wdata = 16'hBEEF; wr_req = 1;
      tick();                                   // E0
      wr_req = 0; Address = 16'hFFFF; wdata = 16'h0000;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("wr_memwr%0d", i), 32'(mem_wr),    32'd1);
         chk($sformatf("wr_addr%0d", i),  32'(mem_addr),  32'h1234);
         chk($sformatf("wr_data%0d", i),  32'(mem_wdata), 32'hBEEF);
         chk($sformatf("wr_done%0d", i),  32'(done),      32'd0);
         if (i == 4) mem_ready = 1;
         tick();
      end
      mem_ready = 0;
      chk("wr_done",  32'(done),   32'd1);
      chk("wr_memwr0",32'(mem_wr), 32'd0);
      chk("wr_memrd", 32'(mem_rd), 32'd0);
      chk("wr_rdata", 32'(rdata),  32'hA5C3);
      chk("wr_ir",    32'(ir),     32'hA5C3);
      tick();
      chk("wr_done1", 32'(done),   32'd0);

      // ---- read timeout ----
      Address = 16'h0100; rd_req = 1; ir_load = 1;
      tick();                                   // E0
      rd_req = 0; ir_load = 0;
      cycles = 0; seen_done = 0;
      while (mem_rd && cycles < 40) begin
         cycles++;
         if (done) seen_done = 1;
         mem_rdata = 16'hDEAD;
         tick();
      end
      chk("to_cycles", 32'(cycles),    32'd15);
      chk("to_err",    32'(err),       32'd1);
      chk("to_done",   32'(done),      32'd0);
      chk("to_nodone", 32'(seen_done), 32'd0);
      chk("to_busy",   32'(busy),      32'd0);
      chk("to_rdata",  32'(rdata),     32'hA5C3);
      chk("to_ir",     32'(ir),        32'hA5C3);
      tick();
      chk("to_err1",   32'(err),       32'd0);

      // ---- ready on the last wait edge: completion wins ----
      Address = 16'h0200; rd_req = 1; ir_load = 0;
      tick();                                   // E0
      rd_req = 0;
      for (int i = 0; i < 14; i++) tick();      // E1..E14 without ready
      chk("bd_busy",  32'(busy), 32'd1);
      chk("bd_err0",  32'(err),  32'd0);
      mem_ready = 1; mem_rdata = 16'h5A5A;
      tick();                                   // E15
      mem_ready = 0;
      chk("bd_done",  32'(done),  32'd1);
      chk("bd_err",   32'(err),   32'd0);
      chk("bd_rdata", 32'(rdata), 32'h5A5A);
      chk("bd_ir",    32'(ir),    32'hA5C3);
      tick();

      // ---- simultaneous request, busy-time request, back-to-back ----
      Address = 16'h0300; wdata = 16'h1111; rd_req = 1; wr_req = 1; ir_load = 0;
      tick();                                   // E0
      rd_req = 0; Address = 16'h0400;           // wr_req stays high while busy
      chk("sim_memrd", 32'(mem_rd),   32'd1);
      chk("sim_memwr", 32'(mem_wr),   32'd0);
      tick();                                   // E1 no ready
      chk("bsy_memwr", 32'(mem_wr),   32'd0);
      chk("bsy_addr",  32'(mem_addr), 32'h0300);
      mem_ready = 1; mem_rdata = 16'h7777;
      tick();                                   // E2 done
      chk("b2b_done",  32'(done),  32'd1);
      chk("b2b_rdata", 32'(rdata), 32'h7777);
      mem_ready = 0; wr_req = 0; rd_req = 1; ir_load = 1; Address = 16'h0500;
      tick();                                   // E3 new read accepted
      rd_req = 0; ir_load = 0;
      chk("b2b_memrd", 32'(mem_rd),   32'd1);
      chk("b2b_addr",  32'(mem_addr), 32'h0500);
      chk("b2b_done0", 32'(done),     32'd0);
      mem_ready = 1; mem_rdata = 16'h0BAD;
      tick();
      chk("b2b_done2", 32'(done),  32'd1);
      chk("b2b_ir",    32'(ir),    32'h0BAD);
      // ready while idle must be ignored
      tick();
      chk("idl_done",  32'(done),  32'd0);
      chk("idl_busy",  32'(busy),  32'd0);
      mem_ready = 0;

      // ---- asynchronous reset mid-read ----
      Address = 16'h0600; rd_req = 1;
      tick();
      rd_req = 0;
      chk("ar_memrd1", 32'(mem_rd), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_memrd", 32'(mem_rd), 32'd0);
      chk("ar_busy",  32'(busy),   32'd0);
      chk("ar_rdata", 32'(rdata),  32'd0);
      chk("ar_ir",    32'(ir),     32'd0);
      mem_ready = 1; mem_rdata = 16'hCAFE;
      tick();
      chk("ar_done",  32'(done),   32'd0);
      chk("ar_err",   32'(err),    32'd0);
      #3 rst_n = 1'b1;
      tick();
      mem_ready = 0;
      chk("ar_done2", 32'(done),   32'd0);
      chk("ar_busy2", 32'(busy),   32'd0);
      chk("ar_rdata2",32'(rdata),  32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
